// File: rtl/nrzi_frame_rx.sv
// nrzi_frame_rx: NRZI line decoder with sync-byte hunt and framed,
// even-parity byte assembly. One decoded bit per clk, MSB first.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | just out of reset; first edge primes din_q, no bit decoded
// ST_HUNT   | shifting decoded bits, looking for SYNC (needs 8 bits)
// ST_DATA   | collecting the 8 data bits of the current byte
// ST_PARITY | current bit is the parity bit; byte is presented here
module nrzi_frame_rx #(
    parameter logic [7:0]  SYNC   = 8'hA5,
    parameter int unsigned NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       perr,
    output logic       frame_done,
    output logic       locked
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);

    state_t     state_q, state_d;
    logic       din_q, din_d;
    logic [7:0] sync_sr_q, sync_sr_d;
    logic [3:0] fill_q, fill_d;
    logic [7:0] data_sr_q, data_sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       perr_q, perr_d;
    logic       dout_valid_q, dout_valid_d;
    logic       frame_done_q, frame_done_d;

    logic       dec_bit;
    logic [7:0] sync_cand;

    // A line transition between consecutive samples is a logical 1.
    assign dec_bit   = din ^ din_q;
    assign sync_cand = {sync_sr_q[6:0], dec_bit};

    // Register all state; reset drops outputs immediately, mid-frame included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            din_q        <= 1'b0;
            sync_sr_q    <= 8'h00;
            fill_q       <= 4'd0;
            data_sr_q    <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'h00;
            dout_q       <= 8'h00;
            perr_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            sync_sr_q    <= sync_sr_d;
            fill_q       <= fill_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            dout_q       <= dout_d;
            perr_q       <= perr_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        state_d      = state_q;
        din_d        = din;
        sync_sr_d    = sync_sr_q;
        fill_d       = fill_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        dout_d       = dout_q;
        perr_d       = perr_q;
        dout_valid_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_HUNT;
            end

            ST_HUNT: begin
                sync_sr_d = sync_cand;
                if (fill_q != 4'd8) begin
                    fill_d = fill_q + 4'd1;
                end
                // fill_q >= 7 guarantees a full byte of real bits, not reset zeros
                if ((fill_q >= 4'd7) && (sync_cand == SYNC)) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'h00;
                end
            end

            ST_DATA: begin
                data_sr_d = {data_sr_q[6:0], dec_bit};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ST_PARITY;
                end
            end

            ST_PARITY: begin
                dout_d       = data_sr_q;
                perr_d       = ^{data_sr_q, dec_bit};
                dout_valid_d = 1'b1;
                byte_cnt_d   = byte_cnt_q + 8'h01;
                if (byte_cnt_q == LAST_BYTE) begin
                    frame_done_d = 1'b1;
                    sync_sr_d    = 8'h00;
                    fill_d       = 4'd0;
                    state_d      = ST_HUNT;
                end else begin
                    state_d = ST_DATA;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign perr       = perr_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign locked     = (state_q == ST_DATA) || (state_q == ST_PARITY);

endmodule

// File: tb/tb_nrzi_frame_rx.sv
// tb_nrzi_frame_rx: three decoder instances share one line. Each run starts
// from reset; outputs are recorded after every edge and compared with a
// frame-parsing reference model, plus table vectors and hand-written cases.
`timescale 1ns/1ps
module tb_nrzi_frame_rx;

    localparam int MAXB = 600;
    localparam int MAXE = MAXB + 1;

    logic clk = 1'b0;
    logic rst;
    logic din;

    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, p0, p1, p2, f0, f1, f2, l0, l1, l2;

    always #5 clk = ~clk;

    nrzi_frame_rx #(.SYNC(8'hA5), .NBYTES(2)) u_dut (
        .clk(clk), .rst(rst), .din(din), .dout(d0), .dout_valid(v0),
        .perr(p0), .frame_done(f0), .locked(l0));
    nrzi_frame_rx #(.SYNC(8'h01), .NBYTES(2)) u_s01 (
        .clk(clk), .rst(rst), .din(din), .dout(d1), .dout_valid(v1),
        .perr(p1), .frame_done(f1), .locked(l1));
    nrzi_frame_rx #(.SYNC(8'hA5), .NBYTES(1)) u_b2b (
        .clk(clk), .rst(rst), .din(din), .dout(d2), .dout_valid(v2),
        .perr(p2), .frame_done(f2), .locked(l2));

    // record layout: {locked, dout_valid, frame_done, perr, dout[7:0]}
    logic [11:0] out_rec [0:2][0:MAXE-1];
    logic [11:0] exp_rec [0:2][0:MAXE-1];
    logic        mdl_bits [0:MAXB-1];
    int          n_bits;
    logic        stim [$];
    logic        line_lvl;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic [7:0] b0;
        logic       pb0;
        logic [7:0] b1;
        logic       pb1;
        logic [7:0] e_d0;
        logic       e_p0;
        logic [7:0] e_d1;
        logic       e_p1;
    } vec_t;
    vec_t vt [5];

    function automatic logic [11:0] obs(input int i);
        case (i)
            0:       return {l0, v0, f0, p0, d0};
            1:       return {l1, v1, f1, p1, d1};
            default: return {l2, v2, f2, p2, d2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic void push_bits(input logic [7:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) stim.push_back(v[i]);
    endfunction

    function automatic void push_frame_byte(input logic [7:0] v, input logic par);
        push_bits(v, 8);
        stim.push_back(par);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        din = 1'b0;
        line_lvl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_state inst%0d", i), obs(i), 12'h000);
        #1 rst = 1'b0;
    endtask

    // Drive stim as decoded bits; edge 0 is the IDLE edge, edge k+1 decodes stim[k].
    task automatic run();
        n_bits = stim.size();
        for (int k = 0; k < n_bits; k++) mdl_bits[k] = stim[k];
        @(negedge clk);
        din = line_lvl;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) out_rec[i][0] = obs(i);
        for (int k = 0; k < n_bits; k++) begin
            @(negedge clk);
            line_lvl = line_lvl ^ stim[k];
            din = line_lvl;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) out_rec[i][k+1] = obs(i);
        end
    endtask

    // Reference: find sync windows in the bit list, then carve 9-bit byte slots.
    function automatic void predict(input int inst, input logic [7:0] sync, input int nb);
        logic       lk   [0:MAXE-1];
        logic       ev_v [0:MAXE-1];
        logic       ev_f [0:MAXE-1];
        logic       ev_p [0:MAXE-1];
        logic [7:0] ev_d [0:MAXE-1];
        logic [7:0] w, by, cur_d;
        logic       cur_p;
        int         pos, j, pk;
        for (int e = 0; e <= n_bits; e++) begin
            lk[e] = 1'b0; ev_v[e] = 1'b0; ev_f[e] = 1'b0; ev_p[e] = 1'b0; ev_d[e] = 8'h00;
        end
        pos = 0;
        while (pos + 7 < n_bits) begin
            j = -1;
            for (int t = pos + 7; t < n_bits && j < 0; t++) begin
                w = 8'h00;
                for (int i = 0; i < 8; i++) w = {w[6:0], mdl_bits[t-7+i]};
                if (w == sync) j = t;
            end
            if (j < 0) break;
            for (int e = j + 1; e <= j + 9*nb && e <= n_bits; e++) lk[e] = 1'b1;
            for (int b = 0; b < nb; b++) begin
                pk = j + 9*(b+1);
                if (pk < n_bits) begin
                    by = 8'h00;
                    for (int i = 0; i < 8; i++) by = {by[6:0], mdl_bits[pk-8+i]};
                    ev_v[pk+1] = 1'b1;
                    ev_d[pk+1] = by;
                    ev_p[pk+1] = (^by) ^ mdl_bits[pk];
                    if (b == nb - 1) ev_f[pk+1] = 1'b1;
                end
            end
            pos = j + 9*nb + 1;
        end
        cur_d = 8'h00;
        cur_p = 1'b0;
        for (int e = 0; e <= n_bits; e++) begin
            if (ev_v[e]) begin
                cur_d = ev_d[e];
                cur_p = ev_p[e];
            end
            exp_rec[inst][e] = {lk[e], ev_v[e], ev_f[e], cur_p, cur_d};
        end
    endfunction

    task automatic check_run(input string tag);
        predict(0, 8'hA5, 2);
        predict(1, 8'h01, 2);
        predict(2, 8'hA5, 1);
        for (int i = 0; i < 3; i++)
            for (int e = 0; e <= n_bits; e++)
                check($sformatf("%s inst%0d edge%0d", tag, i, e), out_rec[i][e], exp_rec[i][e]);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        int         fd_cnt;

        vt[0] = '{8'h3C, 1'b0, 8'h81, 1'b0, 8'h3C, 1'b0, 8'h81, 1'b0};
        vt[1] = '{8'h3C, 1'b1, 8'h81, 1'b0, 8'h3C, 1'b1, 8'h81, 1'b0};
        vt[2] = '{8'hA5, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1};
        vt[3] = '{8'hFF, 1'b0, 8'h07, 1'b1, 8'hFF, 1'b0, 8'h07, 1'b0};
        vt[4] = '{8'h07, 1'b0, 8'hA5, 1'b1, 8'h07, 1'b1, 8'hA5, 1'b1};

        rst = 1'b1;
        din = 1'b0;
        line_lvl = 1'b0;

        // Table vectors: sync, two bytes, two idle bits on the 2-byte A5 instance.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            stim.delete();
            push_bits(8'hA5, 8);
            push_frame_byte(vt[r].b0, vt[r].pb0);
            push_frame_byte(vt[r].b1, vt[r].pb1);
            push_bits(8'h00, 2);
            run();
            check($sformatf("tbl%0d no_lock_e7", r), out_rec[0][7][11], 1'b0);
            check($sformatf("tbl%0d lock_e8", r), out_rec[0][8][11], 1'b1);
            check($sformatf("tbl%0d strobe1", r), out_rec[0][17], {1'b1, 1'b1, 1'b0, vt[r].e_p0, vt[r].e_d0});
            check($sformatf("tbl%0d gap_e18", r), out_rec[0][18], {1'b1, 1'b0, 1'b0, vt[r].e_p0, vt[r].e_d0});
            check($sformatf("tbl%0d strobe2", r), out_rec[0][26], {1'b0, 1'b1, 1'b1, vt[r].e_p1, vt[r].e_d1});
            check($sformatf("tbl%0d hold_e27", r), out_rec[0][27], {1'b0, 1'b0, 1'b0, vt[r].e_p1, vt[r].e_d1});
            check_run($sformatf("tbl%0d", r));
        end

        // Early-match guard on the SYNC=01 instance.
        do_reset();
        stim.delete();
        stim.push_back(1'b0);
        stim.push_back(1'b1);
        for (int i = 0; i < 20; i++) stim.push_back(1'b0);
        stim.push_back(1'b1);
        push_frame_byte(8'h5A, 1'b0);
        push_frame_byte(8'hC3, 1'b0);
        run();
        for (int e = 0; e <= 22; e++) check($sformatf("guard no_lock e%0d", e), out_rec[1][e][11], 1'b0);
        check("guard lock_e23", out_rec[1][23][11], 1'b1);
        check("guard strobe1", out_rec[1][32], {1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
        check_run("guard");

        // Asynchronous reset four bits into the first data byte.
        do_reset();
        stim.delete();
        push_bits(8'hA5, 8);
        push_bits(8'hB0, 4);
        run();
        check_run("partial");
        check("partial locked_before_rst", out_rec[0][12][11], 1'b1);
        #1 rst = 1'b1;
        din = 1'b0;
        line_lvl = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("midrst_clear inst%0d", i), obs(i), 12'h000);
        #1 rst = 1'b0;
        stim.delete();
        push_bits(8'hA5, 8);
        push_frame_byte(8'h3C, 1'b0);
        push_frame_byte(8'h81, 1'b0);
        push_bits(8'h00, 1);
        run();
        check("after_rst idle_edge", out_rec[0][0], 12'h000);
        check("after_rst strobe1", out_rec[0][17], {4'b1100, 8'h3C});
        check("after_rst strobe2", out_rec[0][26], {4'b0110, 8'h81});
        check_run("after_rst");

        // Back-to-back single-byte frames with no gap bits.
        do_reset();
        stim.delete();
        push_bits(8'hA5, 8);
        push_frame_byte(8'h3C, 1'b0);
        push_bits(8'hA5, 8);
        push_frame_byte(8'h81, 1'b1);
        push_bits(8'h00, 3);
        run();
        check("b2b fd_e17", out_rec[2][17][9], 1'b1);
        check("b2b fd_e34", out_rec[2][34], {4'b0111, 8'h81});
        fd_cnt = 0;
        for (int e = 18; e < 34; e++) fd_cnt += int'(out_rec[2][e][9]);
        check("b2b fd_between", fd_cnt, 0);
        check("b2b relock_e25", out_rec[2][25][11], 1'b1);
        check_run("b2b");

        // Randomized line traffic: noise, embedded syncs, good and bad parity.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            stim.delete();
            while (stim.size() < 250) begin
                case ($urandom_range(0, 3))
                    0: begin
                        repeat ($urandom_range(0, 10)) stim.push_back(1'($urandom_range(0, 1)));
                    end
                    1, 2: begin
                        push_bits(($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h01, 8);
                        repeat ($urandom_range(1, 3)) begin
                            rd = 8'($urandom);
                            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
                            push_frame_byte(rd, rp);
                        end
                    end
                    default: begin
                        push_bits(8'($urandom), 8);
                    end
                endcase
            end
            run();
            check_run($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nrzi_frame_rx.md
# nrzi_frame_rx

Serial receive-side decoder for the single-bit line produced by the team's toggle-on-one Moore encoder. The line toggles on every logical 1 and holds on every 0, one bit per `clk`. The block NRZI-decodes the line, hunts for a sync byte, then assembles a fixed number of parity-protected bytes and presents each byte with a one-cycle valid strobe. It sits directly behind the line input, in front of any byte-wide consumer.

## Interface
- `SYNC`, 8'hA5: sync byte, matched MSB-first on decoded bits; any 8-bit value is legal.
- `NBYTES`, 4: data bytes per frame after sync; legal range 1..255.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- `din`  input  1  encoded line, synchronous to `clk`, one bit per cycle.
- `dout`  output  8  last received data byte, MSB first on line; holds between strobes.
- `dout_valid`  output  1  one-cycle pulse: `dout` and `perr` updated this cycle.
- `perr`  output  1  parity error for the byte in `dout`; valid with `dout_valid`, holds after.
- `frame_done`  output  1  one-cycle pulse coincident with `dout_valid` of byte `NBYTES`.
- `locked`  output  1  high while in DATA or PARITY, i.e. a sync has been matched.

## Operation
- Decoded bit each cycle: `bit = din XOR din_q`, where `din_q` is `din` registered on the previous edge. `din_q` resets to 0; the line idles low.
- States and transitions:
  - IDLE: entered on reset. On the first edge it captures `din` into `din_q`, decodes no bit, and goes to HUNT.
  - HUNT: shifts `bit` into 8-bit `sync_sr` (LSB in) and increments a 4-bit fill count, saturating at 8. When fill count ≥ 7 before the shift and `{sync_sr[6:0], bit} == SYNC`, it goes to DATA and clears `bit_cnt` and `byte_cnt`. A match therefore needs at least 8 decoded bits since HUNT entry.
  - DATA: shifts `bit` into 8-bit `data_sr` (LSB in, so first bit ends in MSB) and increments 3-bit `bit_cnt`. On the edge that shifts the 8th bit (`bit_cnt == 7`) it goes to PARITY.
  - PARITY: the current bit is the parity bit; even parity applies over 8 data bits plus parity.
    - On this edge: `dout <= data_sr`, `perr <= ^{data_sr, bit}`, `dout_valid <= 1`, `byte_cnt <= byte_cnt + 1`.
    - If `byte_cnt == NBYTES-1`: `frame_done <= 1`, clear `sync_sr` and fill count, go to HUNT.
    - Otherwise go to DATA.
- A parity error does not abort the frame; all `NBYTES` bytes are always delivered.
- No sync search runs while `locked`; a SYNC pattern inside the data is treated as data.
- Outputs are registered (Moore). `locked` is decoded from the state register.
- Widths: `byte_cnt` 8 bits with no wrap, bounded by `NBYTES` ≤ 255; the fill count saturates at 8.

## Timing
- Reset values: `dout` 8'h00, `dout_valid` 0, `perr` 0, `frame_done` 0, `locked` 0; state IDLE, all shift registers and counters 0.
- `rst` asserted mid-frame clears everything asynchronously. The partial byte is discarded and no strobe is issued. After release, IDLE spends one cycle, then HUNT restarts from empty.
- Sync-to-lock: `locked` rises the cycle after the edge that samples the last sync bit.
- Byte latency: `dout_valid` is high in the cycle after the edge sampling that byte's parity bit.
- Strobe spacing: strobes are exactly 9 cycles apart within a frame, and there are no gaps.
- After `frame_done`, `locked` falls in the same cycle. The next sync needs 8 more decoded bits, so the earliest relock is 8 edges later; back-to-back frames with no gap bits are supported.

## Test plan
- Reset then clean frame: SYNC=A5, NBYTES=2, decoded bits A5, 3C+p0, 81+p0 → two strobes 9 cycles apart.
  - Strobe 1: `dout`=3C, `perr`=0.
  - Strobe 2: `dout`=81, `perr`=0, `frame_done`=1.
  - `locked` falls with the second strobe.
- Parity error: byte 3C sent with parity bit 1 → `dout`=3C, `perr`=1. The next byte still arrives 9 cycles later with `perr`=0.
- Early-match guard: SYNC=8'h01, 20 decoded zeros then bit 1 → no lock before 8 decoded bits; lock only on the 1 after ≥7 zeros. Bits 0,1 right after reset produce no lock.
- False sync in data: data byte A5 inside a locked frame → delivered as `dout`=A5, with no relock or restart.
- Async reset mid-byte: assert `rst` for a partial clock after 4 data bits → all outputs 0 immediately, no strobe. A full frame resent after release decodes correctly.
- Back-to-back frames: NBYTES=1, two frames with no idle bits → two `frame_done` pulses 17 cycles apart (8 sync + 9 byte).
